// File: rtl/sysid_pkg.sv
// +----------------------------------------------------------------------------+
// | sysid_pkg - shared FSM state, addresses and defaults for sysid_check_ctrl  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_ID = 3'd1,
    ST_LAT_ID = 3'd2,
    ST_REQ_TS = 3'd3,
    ST_LAT_TS = 3'd4,
    ST_DONE   = 3'd5
  } sysid_state_e;

  localparam logic        SYSID_ADDR_ID    = 1'b0;
  localparam logic        SYSID_ADDR_TS    = 1'b1;
  localparam logic [31:0] SYSID_DEFAULT_TS = 32'd1642426435;

endpackage

`default_nettype wire

// File: rtl/avm_single_read.sv
// +----------------------------------------------------------------------------+
// | avm_single_read - one Avalon-MM read: waitrequest, latency and timeout     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module avm_single_read #(
  parameter int READ_LATENCY   = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic go_i,
  input  logic addr_i,
  input  logic avm_waitrequest_i,
  output logic avm_read_o,
  output logic avm_address_o,
  output logic accept_o,
  output logic data_valid_o,
  output logic timed_out_o
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       LAT_LAST = (READ_LATENCY == 0) ? 2'd0 : 2'(READ_LATENCY - 1);

  logic             read_q, read_d;
  logic             lat_q, lat_d;
  logic             addr_q, addr_d;
  logic [1:0]       lat_cnt_q, lat_cnt_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             active;

  assign active        = read_q | lat_q;
  assign accept_o      = read_q & ~avm_waitrequest_i;
  assign data_valid_o  = (READ_LATENCY == 0) ? accept_o : (lat_q && (lat_cnt_q == LAT_LAST));
  // A completing access wins over a timeout landing in the same cycle.
  assign timed_out_o   = active && !data_valid_o && (tmo_cnt_q == TMO_LAST);
  assign avm_read_o    = read_q;
  assign avm_address_o = addr_q;

  always_comb begin
    read_d    = read_q;
    lat_d     = lat_q;
    addr_d    = addr_q;
    lat_cnt_d = lat_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    if (active) begin
      tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    end
    if (lat_q) begin
      lat_cnt_d = lat_cnt_q + 2'd1;
    end
    if (accept_o && (READ_LATENCY != 0)) begin
      read_d    = 1'b0;
      lat_d     = 1'b1;
      lat_cnt_d = 2'd0;
    end
    if (data_valid_o || timed_out_o) begin
      read_d = 1'b0;
      lat_d  = 1'b0;
    end
    // A new access may be launched in the same cycle the previous one completes.
    if (go_i) begin
      read_d    = 1'b1;
      lat_d     = 1'b0;
      addr_d    = addr_i;
      tmo_cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      read_q    <= 1'b0;
      lat_q     <= 1'b0;
      addr_q    <= 1'b0;
      lat_cnt_q <= 2'd0;
      tmo_cnt_q <= '0;
    end else begin
      read_q    <= read_d;
      lat_q     <= lat_d;
      addr_q    <= addr_d;
      lat_cnt_q <= lat_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sysid_check_ctrl.sv
// +----------------------------------------------------------------------------+
// | sysid_check_ctrl - reads system-ID and timestamp words and checks them     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module sysid_check_ctrl
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata
);

  sysid_state_e state_q;
  logic         auto_q;
  logic         busy_q, done_q, pass_q, id_ok_q, ts_ok_q, timeout_q;
  logic [31:0]  id_value_q, ts_value_q;
  logic         go, go_addr;
  logic         accept, data_valid, timed_out;
  logic         id_match, ts_match;

  avm_single_read #(
    .READ_LATENCY  (READ_LATENCY),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_read (
    .clock            (clock),
    .reset            (reset),
    .go_i             (go),
    .addr_i           (go_addr),
    .avm_waitrequest_i(avm_waitrequest),
    .avm_read_o       (avm_read),
    .avm_address_o    (avm_address),
    .accept_o         (accept),
    .data_valid_o     (data_valid),
    .timed_out_o      (timed_out)
  );

  assign id_match = (id_value_q == EXPECTED_ID);
  assign ts_match = (avm_readdata == EXPECTED_TS);

  // Launch requests one cycle ahead so the read engine's command is registered.
  always_comb begin
    go      = 1'b0;
    go_addr = SYSID_ADDR_ID;
    case (state_q)
      ST_IDLE, ST_DONE:   go = start | auto_q;
      ST_REQ_ID, ST_LAT_ID: begin
        go      = data_valid;
        go_addr = SYSID_ADDR_TS;
      end
      default: go = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      auto_q     <= AUTO_START;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= 32'h0;
      ts_value_q <= 32'h0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start || auto_q) begin
            state_q   <= ST_REQ_ID;
            auto_q    <= 1'b0;
            busy_q    <= 1'b1;
            pass_q    <= 1'b0;
            id_ok_q   <= 1'b0;
            ts_ok_q   <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        ST_REQ_ID, ST_LAT_ID: begin
          if (data_valid) begin
            id_value_q <= avm_readdata;
            state_q    <= ST_REQ_TS;
          end else if (timed_out) begin
            state_q   <= ST_DONE;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else if (state_q == ST_REQ_ID && accept) begin
            state_q <= ST_LAT_ID;
          end
        end
        ST_REQ_TS, ST_LAT_TS: begin
          if (data_valid) begin
            ts_value_q <= avm_readdata;
            id_ok_q    <= id_match;
            ts_ok_q    <= ts_match;
            pass_q     <= id_match & ts_match;
            state_q    <= ST_DONE;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
          end else if (timed_out) begin
            state_q   <= ST_DONE;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else if (state_q == ST_REQ_TS && accept) begin
            state_q <= ST_LAT_TS;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign id_ok    = id_ok_q;
  assign ts_ok    = ts_ok_q;
  assign timeout  = timeout_q;
  assign id_value = id_value_q;
  assign ts_value = ts_value_q;

endmodule

`default_nettype wire
